uart_prog_loader: RTL

//  Serial program loader that feeds the i_ram write port (din/w_addr/w_en).

---
 rtl/uart_prog_loader.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_prog_loader.sv
// Purpose : 8N1 UART program loader; writes a checksummed image of 16-bit words into i_ram from address 0.
// Latency : o_w_en pulses the cycle after the D_LO stop-bit sample; o_done/o_cpu_hold update the cycle after the CSUM stop sample.
// Backpr. : none; the serial source is unthrottled, and bytes that arrive while DONE or IDLE are dropped.
//
// Ports:
//   i_clk       system clock
//   i_reset_n   asynchronous active-low reset
//   i_rx        UART receive line (idle high, asynchronous to i_clk)
//   i_load_en   1 = wait for an image, 0 = release the CPU straight away (ROM boot); sampled only in IDLE
//   o_w_addr    i_ram write address
//   o_w_data    i_ram write data
//   o_w_en      i_ram write strobe, one cycle per word
//   o_cpu_hold  1 = hold the CPU in reset
//   o_busy      frame in progress (sync byte seen, checksum not yet resolved)
//   o_done      sticky: verified image loaded
//   o_err       sticky: last frame failed; cleared by the next sync byte
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int ADDR_W       = 12,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_rx,
  input  logic              i_load_en,
  output logic [ADDR_W-1:0] o_w_addr,
  output logic [15:0]       o_w_data,
  output logic              o_w_en,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam int                TO_CYC    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int                TO_W      = $clog2(TO_CYC);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_CYC - 1);
  localparam logic [16:0]       MAX_WORDS = 17'd1 << ADDR_W;
  localparam logic [7:0]        SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    F_IDLE, F_WAIT_SYNC, F_LEN_H, F_LEN_L, F_DATA_H, F_DATA_L, F_CSUM, F_DONE
  } fr_state_t;

  // ---------------- RX front end ----------------
  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t        r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             w_byte_vld, w_frame_err, w_fall;

  assign w_fall = r_rx_prev & ~r_rx_sync;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      r_rx_meta  <= i_rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_state <= w_rx_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_cnt_nxt      = r_cnt + 1'b1;
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_byte_vld     = 1'b0;
    w_frame_err    = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) w_rx_state_nxt = RX_START;
      end
      RX_START: begin
        // Mid-start-bit resample: a line already back high was a glitch.
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt     = '0;
          w_shift_nxt   = {r_rx_sync, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 1'b1;
          if (r_bit_idx == 3'd7) w_rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt      = '0;
          w_rx_state_nxt = RX_IDLE;
          w_byte_vld     = r_rx_sync;
          w_frame_err    = ~r_rx_sync;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------- Frame FSM ----------------
  fr_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_w_addr, w_w_addr_nxt;
  logic [ADDR_W-1:0] r_last, w_last_nxt;
  logic [15:0]       r_w_data, w_w_data_nxt;
  logic              r_w_en, w_w_en_nxt;
  logic              r_cpu_hold, w_cpu_hold_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic [7:0]        r_len_hi, w_len_hi_nxt;
  logic [7:0]        r_hi, w_hi_nxt;
  logic [7:0]        r_sum, w_sum_nxt;
  logic [TO_W-1:0]   r_to, w_to_nxt;
  logic [15:0]       w_len;
  logic              w_in_frame, w_to_hit;

  assign w_len      = {r_len_hi, r_shift};
  assign w_in_frame = (r_state == F_LEN_H) || (r_state == F_LEN_L) || (r_state == F_DATA_H) ||
                      (r_state == F_DATA_L) || (r_state == F_CSUM);
  assign w_to_hit   = w_in_frame && (r_to == TO_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= F_IDLE;
      r_w_addr   <= '0;
      r_last     <= '0;
      r_w_data   <= '0;
      r_w_en     <= 1'b0;
      r_cpu_hold <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_len_hi   <= '0;
      r_hi       <= '0;
      r_sum      <= '0;
      r_to       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_w_addr   <= w_w_addr_nxt;
      r_last     <= w_last_nxt;
      r_w_data   <= w_w_data_nxt;
      r_w_en     <= w_w_en_nxt;
      r_cpu_hold <= w_cpu_hold_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_len_hi   <= w_len_hi_nxt;
      r_hi       <= w_hi_nxt;
      r_sum      <= w_sum_nxt;
      r_to       <= w_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_w_addr_nxt   = r_w_addr;
    w_last_nxt     = r_last;
    w_w_data_nxt   = r_w_data;
    w_w_en_nxt     = 1'b0;
    w_cpu_hold_nxt = r_cpu_hold;
    w_busy_nxt     = r_busy;
    w_done_nxt     = r_done;
    w_err_nxt      = r_err;
    w_len_hi_nxt   = r_len_hi;
    w_hi_nxt       = r_hi;
    w_sum_nxt      = r_sum;
    w_to_nxt       = w_in_frame ? r_to + 1'b1 : '0;

    // Saturating advance: the length check makes the top address the last write, so no wrap.
    if (r_w_en && (r_w_addr != '1)) w_w_addr_nxt = r_w_addr + 1'b1;

    case (r_state)
      F_IDLE: begin
        if (i_load_en) w_state_nxt    = F_WAIT_SYNC;
        else           w_cpu_hold_nxt = 1'b0;
      end
      F_WAIT_SYNC: begin
        if (w_frame_err) begin
          w_err_nxt = 1'b1;
        end else if (w_byte_vld && (r_shift == SYNC_BYTE)) begin
          w_state_nxt  = F_LEN_H;
          w_busy_nxt   = 1'b1;
          w_err_nxt    = 1'b0;
          w_sum_nxt    = '0;
          w_w_addr_nxt = '0;
        end
      end
      F_DONE: ;
      default: begin
        if (w_frame_err || (w_to_hit && !w_byte_vld)) begin
          w_state_nxt = F_WAIT_SYNC;
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
        end else if (w_byte_vld) begin
          w_to_nxt  = '0;
          w_sum_nxt = r_sum + r_shift;
          case (r_state)
            F_LEN_H: begin
              w_len_hi_nxt = r_shift;
              w_state_nxt  = F_LEN_L;
            end
            F_LEN_L: begin
              if ((w_len == 16'd0) || ({1'b0, w_len} > MAX_WORDS)) begin
                w_state_nxt = F_WAIT_SYNC;
                w_err_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
              end else begin
                w_last_nxt  = ADDR_W'(w_len - 16'd1);
                w_state_nxt = F_DATA_H;
              end
            end
            F_DATA_H: begin
              w_hi_nxt    = r_shift;
              w_state_nxt = F_DATA_L;
            end
            F_DATA_L: begin
              w_w_data_nxt = {r_hi, r_shift};
              w_w_en_nxt   = 1'b1;
              w_state_nxt  = (r_w_addr == r_last) ? F_CSUM : F_DATA_H;
            end
            F_CSUM: begin
              w_busy_nxt = 1'b0;
              if (r_sum == r_shift) begin
                w_state_nxt    = F_DONE;
                w_done_nxt     = 1'b1;
                w_cpu_hold_nxt = 1'b0;
              end else begin
                w_state_nxt = F_WAIT_SYNC;
                w_err_nxt   = 1'b1;
              end
            end
            default: w_state_nxt = F_WAIT_SYNC;
          endcase
        end
      end
    endcase
  end

  assign o_w_addr   = r_w_addr;
  assign o_w_data   = r_w_data;
  assign o_w_en     = r_w_en;
  assign o_cpu_hold = r_cpu_hold;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule
